id_ex_dual_issue: RTL

ID_EX_DUAL_ISSUE -- requirements
Module: id_ex_dual_issue

---
 rtl/id_ex_dual_issue.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/id_ex_dual_issue.sv
// ID/EX pipeline register for a dual-issue pair. Slot A feeds ALU A and slot B
// feeds ALU B. When B reads the rd that A writes in the same pair, the pair is
// split: A issues first, B is parked and issues one cycle later. B then takes
// A's result from fwd_a_data for whichever of its sources match.
module id_ex_dual_issue #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned OPRW = 4,
  parameter int unsigned RW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_a_v,
  input  logic            in_b_v,
  input  logic [OPRW-1:0] in_a_opr,
  input  logic [OPRW-1:0] in_b_opr,
  input  logic [XLEN-1:0] in_a_op1,
  input  logic [XLEN-1:0] in_a_op2,
  input  logic [XLEN-1:0] in_b_op1,
  input  logic [XLEN-1:0] in_b_op2,
  input  logic [RW-1:0]   in_a_rd,
  input  logic [RW-1:0]   in_a_rs1,
  input  logic [RW-1:0]   in_a_rs2,
  input  logic [RW-1:0]   in_b_rd,
  input  logic [RW-1:0]   in_b_rs1,
  input  logic [RW-1:0]   in_b_rs2,
  input  logic            in_a_we,
  input  logic            in_b_we,
  input  logic            out_ready,
  input  logic [XLEN-1:0] fwd_a_data,
  output logic            a_valid,
  output logic [OPRW-1:0] a_opr,
  output logic [XLEN-1:0] a_op1,
  output logic [XLEN-1:0] a_op2,
  output logic [RW-1:0]   a_rd,
  output logic            a_we,
  output logic            b_valid,
  output logic [OPRW-1:0] b_opr,
  output logic [XLEN-1:0] b_op1,
  output logic [XLEN-1:0] b_op2,
  output logic [RW-1:0]   b_rd,
  output logic            b_we
);

  typedef enum logic [0:0] {StRun, StSplit} state_e;

  state_e          state_q, state_d;
  logic            a_valid_q, a_valid_d, a_we_q, a_we_d;
  logic [OPRW-1:0] a_opr_q, a_opr_d;
  logic [XLEN-1:0] a_op1_q, a_op1_d, a_op2_q, a_op2_d;
  logic [RW-1:0]   a_rd_q, a_rd_d;
  logic            b_valid_q, b_valid_d, b_we_q, b_we_d;
  logic [OPRW-1:0] b_opr_q, b_opr_d;
  logic [XLEN-1:0] b_op1_q, b_op1_d, b_op2_q, b_op2_d;
  logic [RW-1:0]   b_rd_q, b_rd_d;
  // Parked slot B; source-match flags are resolved at capture against A's rd.
  logic [OPRW-1:0] hold_opr_q, hold_opr_d;
  logic [XLEN-1:0] hold_op1_q, hold_op1_d, hold_op2_q, hold_op2_d;
  logic [RW-1:0]   hold_rd_q, hold_rd_d;
  logic            hold_we_q, hold_we_d;
  logic            hold_m1_q, hold_m1_d, hold_m2_q, hold_m2_d;

  logic accept, hazard;
  // Slot A sources never matter here; A's operands arrive already resolved.
  logic unused_a_rs;
  assign unused_a_rs = ^{in_a_rs1, in_a_rs2};

  assign in_ready = out_ready & (state_q == StRun) & ~flush;
  assign accept   = in_valid & in_ready;
  assign hazard   = in_a_v & in_b_v & in_a_we & (in_a_rd != '0) &
                    ((in_b_rs1 == in_a_rd) | (in_b_rs2 == in_a_rd));

  // Next-state: flush first, then advance only when execute accepts.
  always_comb begin
    state_d    = state_q;
    a_valid_d  = a_valid_q;  a_we_d  = a_we_q;  a_opr_d = a_opr_q;
    a_op1_d    = a_op1_q;    a_op2_d = a_op2_q; a_rd_d  = a_rd_q;
    b_valid_d  = b_valid_q;  b_we_d  = b_we_q;  b_opr_d = b_opr_q;
    b_op1_d    = b_op1_q;    b_op2_d = b_op2_q; b_rd_d  = b_rd_q;
    hold_opr_d = hold_opr_q; hold_op1_d = hold_op1_q; hold_op2_d = hold_op2_q;
    hold_rd_d  = hold_rd_q;  hold_we_d  = hold_we_q;
    hold_m1_d  = hold_m1_q;  hold_m2_d  = hold_m2_q;
    if (flush) begin
      a_valid_d = 1'b0;
      a_we_d    = 1'b0;
      b_valid_d = 1'b0;
      b_we_d    = 1'b0;
      hold_we_d = 1'b0;
      state_d   = StRun;
    end else if (out_ready) begin
      unique case (state_q)
        StRun: begin
          if (accept) begin
            a_valid_d = in_a_v;
            a_we_d    = in_a_v & in_a_we;
            a_opr_d   = in_a_opr;
            a_op1_d   = in_a_op1;
            a_op2_d   = in_a_op2;
            a_rd_d    = in_a_rd;
            if (hazard) begin
              b_valid_d  = 1'b0;
              b_we_d     = 1'b0;
              hold_opr_d = in_b_opr;
              hold_op1_d = in_b_op1;
              hold_op2_d = in_b_op2;
              hold_rd_d  = in_b_rd;
              hold_we_d  = in_b_we;
              hold_m1_d  = (in_b_rs1 == in_a_rd);
              hold_m2_d  = (in_b_rs2 == in_a_rd);
              state_d    = StSplit;
            end else begin
              b_valid_d = in_b_v;
              b_we_d    = in_b_v & in_b_we;
              b_opr_d   = in_b_opr;
              b_op1_d   = in_b_op1;
              b_op2_d   = in_b_op2;
              b_rd_d    = in_b_rd;
            end
          end else begin
            a_valid_d = 1'b0;
            a_we_d    = 1'b0;
            b_valid_d = 1'b0;
            b_we_d    = 1'b0;
          end
        end
        StSplit: begin
          a_valid_d = 1'b0;
          a_we_d    = 1'b0;
          b_valid_d = 1'b1;
          b_we_d    = hold_we_q;
          b_opr_d   = hold_opr_q;
          b_op1_d   = hold_m1_q ? fwd_a_data : hold_op1_q;
          b_op2_d   = hold_m2_q ? fwd_a_data : hold_op2_q;
          b_rd_d    = hold_rd_q;
          state_d   = StRun;
        end
        default: state_d = StRun;
      endcase
    end
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRun;
      a_valid_q  <= 1'b0; a_we_q  <= 1'b0; a_opr_q <= '0;
      a_op1_q    <= '0;   a_op2_q <= '0;   a_rd_q  <= '0;
      b_valid_q  <= 1'b0; b_we_q  <= 1'b0; b_opr_q <= '0;
      b_op1_q    <= '0;   b_op2_q <= '0;   b_rd_q  <= '0;
      hold_opr_q <= '0;   hold_op1_q <= '0; hold_op2_q <= '0;
      hold_rd_q  <= '0;   hold_we_q  <= 1'b0;
      hold_m1_q  <= 1'b0; hold_m2_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_valid_q  <= a_valid_d; a_we_q  <= a_we_d;  a_opr_q <= a_opr_d;
      a_op1_q    <= a_op1_d;   a_op2_q <= a_op2_d; a_rd_q  <= a_rd_d;
      b_valid_q  <= b_valid_d; b_we_q  <= b_we_d;  b_opr_q <= b_opr_d;
      b_op1_q    <= b_op1_d;   b_op2_q <= b_op2_d; b_rd_q  <= b_rd_d;
      hold_opr_q <= hold_opr_d; hold_op1_q <= hold_op1_d; hold_op2_q <= hold_op2_d;
      hold_rd_q  <= hold_rd_d;  hold_we_q  <= hold_we_d;
      hold_m1_q  <= hold_m1_d;  hold_m2_q  <= hold_m2_d;
    end
  end

  assign a_valid = a_valid_q;
  assign a_opr   = a_opr_q;
  assign a_op1   = a_op1_q;
  assign a_op2   = a_op2_q;
  assign a_rd    = a_rd_q;
  assign a_we    = a_we_q;
  assign b_valid = b_valid_q;
  assign b_opr   = b_opr_q;
  assign b_op1   = b_op1_q;
  assign b_op2   = b_op2_q;
  assign b_rd    = b_rd_q;
  assign b_we    = b_we_q;

endmodule
